// File: rtl/crc32_eth_stream.sv
// Streaming Ethernet CRC-32 engine (reflected poly 0xEDB88320, init/xorout all-ones).
// Folds DATA_W/8 bytes per beat in lane order, reports the FCS one cycle after
// the eop beat, checks the residue for frames that carry their own FCS, and
// counts completed frames and framing errors.
//
// Handshake: s_valid qualifies s_sop, s_eop, s_data and s_keep in the same
// cycle. The block is always ready; a beat is taken on every cycle where
// s_valid is high. s_keep is only looked at on eop beats.
module crc32_eth_stream #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic                  s_sop,
  input  logic                  s_eop,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [DATA_W/8-1:0]   s_keep,
  output logic                  crc_valid,
  output logic [31:0]           crc_out,
  output logic                  crc_ok,
  output logic                  busy,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  state_dbg
);

  localparam int          BYTES       = DATA_W / 8;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  state_t            state;
  logic [31:0]       crc_reg;
  logic [31:0]       crc_next;
  logic [BYTES-1:0]  keep_inc;
  logic              bad_keep;
  logic              accept;
  logic              err_inc;

  assign state_dbg = state;

  // One byte of the reflected CRC, bit-serial inside the byte (unrolled by synthesis).
  function automatic logic [31:0] fold_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Thermometer keep has no set bit above a clear bit: keep & (keep+1) == 0.
  assign keep_inc = s_keep + BYTES'(1);
  assign bad_keep = s_eop && ((s_keep & keep_inc) != '0);

  // A beat belongs to a frame if it opens one or continues the current one.
  assign accept = s_valid && (s_sop || (state == IN_FRAME));

  // Orphan beat, abort, or bad keep; several at once still count as one error.
  assign err_inc = s_valid && (((state == IDLE) && !s_sop) ||
                               ((state == IN_FRAME) && s_sop) ||
                               (accept && bad_keep));

  // Fold the enabled lanes of this beat, starting fresh on sop.
  always_comb begin
    crc_next = s_sop ? CRC_INIT : crc_reg;
    for (int i = 0; i < BYTES; i++) begin
      if (!s_eop || s_keep[i]) begin
        crc_next = fold_byte(crc_next, s_data[8*i +: 8]);
      end
    end
  end

  // Frame FSM, CRC register, registered results and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      crc_reg   <= CRC_INIT;
      crc_valid <= 1'b0;
      crc_out   <= 32'h0;
      crc_ok    <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      crc_valid <= 1'b0;
      if (err_inc && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (accept) begin
        if (s_eop) begin
          state   <= IDLE;
          busy    <= 1'b0;
          crc_reg <= CRC_INIT;
          if (!bad_keep) begin
            crc_valid <= 1'b1;
            crc_out   <= ~crc_next;
            crc_ok    <= (crc_next == CRC_RESIDUE);
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end else begin
          state   <= IN_FRAME;
          busy    <= 1'b1;
          crc_reg <= crc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc32_eth_stream.sv
// Bench for crc32_eth_stream: a byte-queue reference model computes every
// output each cycle; directed frames add literal expectations from the
// well-known "123456789" check value.
module tb_crc32_eth_stream;

  localparam int DATA_W = 32;
  localparam int BYTES  = DATA_W / 8;
  localparam int CNT_W  = 16;

  typedef byte unsigned bq_t[$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic              s_valid, s_sop, s_eop;
  logic [DATA_W-1:0] s_data;
  logic [BYTES-1:0]  s_keep;
  logic              crc_valid, crc_ok, busy, state_dbg;
  logic [31:0]       crc_out;
  logic [CNT_W-1:0]  frame_cnt, err_cnt;

  // 8-bit instance
  logic              d8_valid, d8_sop, d8_eop;
  logic [7:0]        d8_data;
  logic [0:0]        d8_keep;
  logic              d8_crc_valid, d8_crc_ok, d8_busy, d8_state_dbg;
  logic [31:0]       d8_crc_out;
  logic [CNT_W-1:0]  d8_frame_cnt, d8_err_cnt;

  crc32_eth_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
    .s_data(s_data), .s_keep(s_keep), .crc_valid(crc_valid), .crc_out(crc_out),
    .crc_ok(crc_ok), .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
    .state_dbg(state_dbg)
  );

  crc32_eth_stream #(.DATA_W(8), .CNT_W(CNT_W)) u_dut8 (
    .clk(clk), .rst(rst), .s_valid(d8_valid), .s_sop(d8_sop), .s_eop(d8_eop),
    .s_data(d8_data), .s_keep(d8_keep), .crc_valid(d8_crc_valid), .crc_out(d8_crc_out),
    .crc_ok(d8_crc_ok), .busy(d8_busy), .frame_cnt(d8_frame_cnt), .err_cnt(d8_err_cnt),
    .state_dbg(d8_state_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_in_frame;
  bq_t              m_q;
  logic             exp_valid, exp_ok, exp_busy;
  logic [31:0]      exp_crc;
  logic [CNT_W-1:0] exp_frame, exp_err;

  // Textbook bit-serial reflected CRC over a whole byte list (register value, no final xor).
  function automatic logic [31:0] crc_raw(input bq_t q);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      b = q[i];
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    bit          err, therm;
    int          n;
    logic [31:0] raw;
    if (rst) begin
      m_in_frame = 1'b0;
      m_q.delete();
      exp_valid = 1'b0; exp_ok = 1'b0; exp_busy = 1'b0;
      exp_crc = 32'h0; exp_frame = '0; exp_err = '0;
    end else begin
      exp_valid = 1'b0;
      err = 1'b0;
      if (s_valid) begin
        if (!m_in_frame && !s_sop) begin
          err = 1'b1;
        end else begin
          if (s_sop) begin
            if (m_in_frame) err = 1'b1;
            m_q.delete();
          end
          n = s_eop ? $countones(s_keep) : BYTES;
          therm = !s_eop || (int'(s_keep) == ((1 << n) - 1));
          if (therm) begin
            for (int i = 0; i < n; i++) m_q.push_back(s_data[8*i +: 8]);
          end
          if (s_eop) begin
            if (therm) begin
              raw = crc_raw(m_q);
              exp_valid = 1'b1;
              exp_crc = ~raw;
              exp_ok = (raw == 32'hDEBB20E3);
              exp_frame = exp_frame + 1'b1;
            end else begin
              err = 1'b1;
            end
            m_in_frame = 1'b0;
            m_q.delete();
          end else begin
            m_in_frame = 1'b1;
          end
        end
        if (err && (exp_err != '1)) exp_err = exp_err + 1'b1;
      end
      exp_busy = m_in_frame;
    end
  end

  // Compare every output against the model on every cycle, away from the sampling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("crc_valid", 32'(crc_valid), 32'(exp_valid));
      check("crc_out",   crc_out,        exp_crc);
      check("crc_ok",    32'(crc_ok),    32'(exp_ok));
      check("busy",      32'(busy),      32'(exp_busy));
      check("frame_cnt", 32'(frame_cnt), 32'(exp_frame));
      check("err_cnt",   32'(err_cnt),   32'(exp_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic beat(input logic sop, input logic eop, input logic [31:0] data,
                      input logic [3:0] keep);
    s_valid = 1'b1; s_sop = sop; s_eop = eop; s_data = data; s_keep = keep;
    @(negedge clk);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  // "123456789" as three 32-bit beats, optional random gaps between beats.
  task automatic send_check(input int max_gap);
    beat(1'b1, 1'b0, 32'h34333231, 4'hF);
    idle($urandom_range(0, max_gap));
    beat(1'b0, 1'b0, 32'h38373635, 4'hF);
    idle($urandom_range(0, max_gap));
    beat(1'b0, 1'b1, 32'h00000039, 4'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_data = '0; s_keep = '0;
    d8_valid = 1'b0; d8_sop = 1'b0; d8_eop = 1'b0; d8_data = '0; d8_keep = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_crc_valid", 32'(crc_valid), 32'h0);
    check("rst_crc_out",   crc_out,        32'h0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    check("rst_err_cnt",   32'(err_cnt),   32'h0);
    rst = 1'b0;

    // Check string, 32-bit beats.
    send_check(0);
    check("chk_valid",    32'(crc_valid), 32'h1);
    check("chk_crc",      crc_out,        32'hCBF43926);
    check("chk_model",    exp_crc,        32'hCBF43926);
    check("chk_ok",       32'(crc_ok),    32'h0);
    check("chk_frames",   32'(frame_cnt), 32'h1);
    idle(1);
    check("chk_hold_crc", crc_out,        32'hCBF43926);
    check("chk_pulse",    32'(crc_valid), 32'h0);

    // Residue: string followed by its FCS, then with one flipped bit.
    beat(1'b1, 1'b0, 32'h34333231, 4'hF);
    check("busy_after_sop", 32'(busy), 32'h1);
    beat(1'b0, 1'b0, 32'h38373635, 4'hF);
    beat(1'b0, 1'b0, 32'hF4392639, 4'hF);
    beat(1'b0, 1'b1, 32'h000000CB, 4'h1);
    check("res_ok",        32'(crc_ok), 32'h1);
    check("res_model_ok",  32'(exp_ok), 32'h1);
    check("busy_after_eop", 32'(busy), 32'h0);
    beat(1'b1, 1'b0, 32'h34333230, 4'hF);
    beat(1'b0, 1'b0, 32'h38373635, 4'hF);
    beat(1'b0, 1'b0, 32'hF4392639, 4'hF);
    beat(1'b0, 1'b1, 32'h000000CB, 4'h1);
    check("res_flip_valid", 32'(crc_valid), 32'h1);
    check("res_flip_ok",    32'(crc_ok),    32'h0);

    // Empty single-beat frame, then partial keeps (model only).
    beat(1'b1, 1'b1, 32'h12345678, 4'h0);
    check("empty_valid", 32'(crc_valid), 32'h1);
    check("empty_crc",   crc_out,        32'h0);
    check("empty_ok",    32'(crc_ok),    32'h0);
    beat(1'b1, 1'b1, 32'hA5C3_0F99, 4'hF);
    beat(1'b1, 1'b0, 32'hDEADBEEF, 4'hF);
    beat(1'b0, 1'b1, 32'hCAFEF00D, 4'h3);
    beat(1'b1, 1'b0, 32'h01020304, 4'hF);
    beat(1'b0, 1'b1, 32'h55AA55AA, 4'h7);
    idle(2);

    // Back-to-back frames with random gaps.
    do_reset();
    send_check(3);
    check("b2b_valid1", 32'(crc_valid), 32'h1);
    check("b2b_crc1",   crc_out,        32'hCBF43926);
    send_check(3);
    check("b2b_valid2", 32'(crc_valid), 32'h1);
    check("b2b_crc2",   crc_out,        32'hCBF43926);
    check("b2b_frames", 32'(frame_cnt), 32'h2);
    idle(1);

    // Framing errors.
    do_reset();
    beat(1'b0, 1'b0, 32'hDEADBEEF, 4'hF);
    check("err_orphan",      32'(err_cnt), 32'h1);
    check("err_orphan_busy", 32'(busy),    32'h0);
    beat(1'b1, 1'b0, 32'hAAAAAAAA, 4'hF);
    beat(1'b0, 1'b0, 32'h55555555, 4'hF);
    send_check(0);
    check("err_abort",       32'(err_cnt),   32'h2);
    check("err_abort_crc",   crc_out,        32'hCBF43926);
    check("err_abort_frame", 32'(frame_cnt), 32'h1);
    beat(1'b1, 1'b0, 32'h34333231, 4'hF);
    beat(1'b0, 1'b1, 32'h38373635, 4'h5);
    check("err_keep",        32'(err_cnt),   32'h3);
    check("err_keep_valid",  32'(crc_valid), 32'h0);
    check("err_keep_frame",  32'(frame_cnt), 32'h1);
    check("err_keep_busy",   32'(busy),      32'h0);
    beat(1'b1, 1'b0, 32'h11111111, 4'hF);
    beat(1'b1, 1'b1, 32'h22222222, 4'h5);
    check("err_double",      32'(err_cnt),   32'h4);
    idle(1);

    // Reset in the middle of a frame; counters are non-zero going in.
    beat(1'b1, 1'b0, 32'h34333231, 4'hF);
    beat(1'b0, 1'b0, 32'h38373635, 4'hF);
    rst = 1'b1;
    idle(1);
    check("rstmid_busy",  32'(busy),      32'h0);
    check("rstmid_frame", 32'(frame_cnt), 32'h0);
    check("rstmid_err",   32'(err_cnt),   32'h0);
    rst = 1'b0;
    send_check(0);
    check("rstmid_crc",    crc_out,        32'hCBF43926);
    check("rstmid_frames", 32'(frame_cnt), 32'h1);
    check("rstmid_errs",   32'(err_cnt),   32'h0);
    idle(2);

    // 8-bit instance: check string one byte per beat.
    for (int i = 0; i < 9; i++) begin
      d8_valid = 1'b1; d8_sop = (i == 0); d8_eop = (i == 8);
      d8_data = 8'h31 + 8'(i); d8_keep = 1'b1;
      @(negedge clk);
      if (i == 4) check("d8_busy", 32'(d8_busy), 32'h1);
    end
    d8_valid = 1'b0; d8_sop = 1'b0; d8_eop = 1'b0;
    check("d8_valid",  32'(d8_crc_valid), 32'h1);
    check("d8_crc",    d8_crc_out,        32'hCBF43926);
    check("d8_ok",     32'(d8_crc_ok),    32'h0);
    check("d8_frames", 32'(d8_frame_cnt), 32'h1);
    check("d8_errs",   32'(d8_err_cnt),   32'h0);
    idle(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crc32_eth_stream.md
# crc32_eth_stream

Parametrised streaming Ethernet CRC-32 engine, successor to the fixed 32-bit `crc` block. It accepts frame data DATA_W bits per beat, with start-of-frame/end-of-frame framing and a byte-keep mask on the last beat. It reports the final FCS, plus a residue check for frames that already carry their FCS. It also keeps frame and error counters. It sits between the MAC byte stream and the TX FCS inserter / RX FCS checker.

## Interface
- DATA_W, 32: beat width in bits; legal values 8, 16, 32, 64. BYTES = DATA_W/8.
- CNT_W, 16: width of the frame and error counters.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  beat present this cycle. The block is always ready; there is no backpressure.
- s_sop  in  1  first beat of a frame; qualified by s_valid.
- s_eop  in  1  last beat of a frame; qualified by s_valid.
- s_data  in  DATA_W  beat data. Lane 0 (bits [7:0]) is first on the wire; bits go LSB-first within each byte.
- s_keep  in  BYTES  valid byte lanes. Sampled only on eop beats; must be thermometer, low-aligned. Non-eop beats are always full.
- crc_valid  out  1  one-cycle pulse when the frame result is available.
- crc_out  out  32  final FCS (~register). crc_out[7:0] is transmitted first.
- crc_ok  out  1  1 if the register equals residue 0xDEBB20E3 at eop; valid with crc_valid.
- busy  out  1  frame in progress.
- frame_cnt  out  CNT_W  frames completed (crc_valid pulses); wraps at 2^CNT_W.
- err_cnt  out  CNT_W  framing errors; saturates at all-ones.

## Operation
- CRC definition: poly 0x04C11DB7 in reflected form 0xEDB88320; init 0xFFFFFFFF; reflected in/out; final XOR 0xFFFFFFFF.
- Each beat: lanes 0..n-1 fold into the register in lane order, all in one cycle (unrolled combinational update). n = BYTES, or popcount(s_keep) on an eop beat.
- States:
  - IDLE → IN_FRAME on s_valid&s_sop&!s_eop. The register loads init folded with the beat.
  - IN_FRAME → IN_FRAME on s_valid&!s_sop&!s_eop. The register folds the beat.
  - IN_FRAME or IDLE → IDLE on s_valid&s_sop&s_eop (single-beat frame) or on s_valid&s_eop in frame. The result is registered and crc_valid pulses.
- Error cases, each incrementing err_cnt by 1:
  - **Data beat in IDLE without s_sop:** the beat is dropped and the state stays IDLE.
  - **s_sop while IN_FRAME:** the current frame is aborted with no crc_valid, and the new frame starts with this beat.
  - **Non-thermometer s_keep on eop:** the beat is consumed, the state returns to IDLE, and crc_valid is suppressed. frame_cnt does not change.
- Empty eop beat: s_keep = 0 on eop is legal and contributes zero bytes. A sop&eop beat with keep 0 therefore gives crc_out = 0x00000000 and crc_ok = 0.
- s_valid low: the state and register hold. Gaps of any length inside a frame are allowed.
- Counters:
  - frame_cnt increments on every crc_valid pulse.
  - err_cnt increments by at most 1 per cycle.
  - If both an abort and a keep error occur on the same beat (sop while IN_FRAME, with bad keep on eop), err_cnt increments by 1 only.

## Timing
- Reset values: crc_valid=0, crc_out=0, crc_ok=0, busy=0, frame_cnt=0, err_cnt=0; state IDLE; register 0xFFFFFFFF.
- Latency: crc_valid, crc_out and crc_ok are registered and appear the cycle after the eop beat is sampled. crc_out and crc_ok hold until the next crc_valid.
- Back-to-back frames: an eop beat may be followed immediately by a sop beat, so frames run at full rate with no idle cycle. Throughput is DATA_W bits per clock.
- busy is 1 from the cycle after the sop beat until the cycle after the eop beat.
- rst asserted mid-frame: the next cycle is IDLE with all outputs at reset values. The partial frame is discarded with no crc_valid, and counters clear.
- Timing target: one DATA_W=64 fold per cycle at the system clock. No multicycle paths.

## Test plan
- **DATA_W=8, check string:** bytes 0x31..0x39 ("123456789"), sop on the first byte, eop on the last → crc_valid one cycle later, crc_out=0xCBF43926, crc_ok=0, frame_cnt=1.
- **DATA_W=32, same string:** beats 0x34333231 (sop), 0x38373635, 0x00000039 (eop, keep=0001) → crc_out=0xCBF43926.
- **DATA_W=32, residue check:** beats 0x34333231 (sop), 0x38373635, 0xF4392639, 0x000000CB (eop, keep=0001) → crc_ok=1. Flipping any data bit → crc_ok=0.
- **Back-to-back with gaps:** two check-string frames with no idle cycle between them, and random s_valid gaps inside each → two crc_valid pulses, both 0xCBF43926, frame_cnt=2.
- **Errors:**
  - Beat without sop in IDLE → err_cnt=1.
  - sop mid-frame → err_cnt=2, and the second frame is still computed correctly.
  - eop with keep=0101 → err_cnt=3 and no crc_valid.
- **Reset mid-frame:** rst after 2 of 3 beats, then a full check-string frame → exactly one crc_valid, crc_out=0xCBF43926, frame_cnt=1, err_cnt=0.
